// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-256/224 constants, working-state types and round helper functions.
package sha2_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } sha2_work_t;

    typedef enum logic [1:0] {
        CTX_IDLE   = 2'd0,
        CTX_ACTIVE = 2'd1,
        CTX_FINAL  = 2'd2
    } ctx_state_e;

    typedef enum logic {
        MODE_SHA256 = 1'b0,
        MODE_SHA224 = 1'b1
    } sha2_mode_e;

    localparam sha2_work_t IV_SHA256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam sha2_work_t IV_SHA224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word-wise modular sum used for the final H update.
    function automatic sha2_work_t add_work(input sha2_work_t x, input sha2_work_t y);
        sha2_work_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha2_round_pipe.sv
// rtl/sha2_round_pipe.sv - 4-stage SHA-2 round datapath; en_i=0 passes the state through unchanged.
module sha2_round_pipe
    import sha2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  sha2_work_t  state_i,
    input  logic [31:0] kw_i,
    output sha2_work_t  state_o
);

    sha2_work_t  st1_q;
    sha2_work_t  st2_q;
    sha2_work_t  st3_q;
    sha2_work_t  st4_q;
    sha2_work_t  rnd_res;
    logic        en1_q;
    logic        en2_q;
    logic [31:0] hkw_q;
    logic [31:0] sig1_q;
    logic [31:0] ch_q;
    logic [31:0] sig0_q;
    logic [31:0] maj_q;
    logic [31:0] t1_q;
    logic [31:0] t2_q;

    always_comb begin
        rnd_res = st2_q;
        if (en2_q) begin
            rnd_res.a = t1_q + t2_q;
            rnd_res.b = st2_q.a;
            rnd_res.c = st2_q.b;
            rnd_res.d = st2_q.c;
            rnd_res.e = st2_q.d + t1_q;
            rnd_res.f = st2_q.e;
            rnd_res.g = st2_q.f;
            rnd_res.h = st2_q.g;
        end
    end

    // Stage 1 evaluates the boolean/sigma terms, stage 2 forms T1/T2, stage 3 rotates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st1_q  <= '0;
            st2_q  <= '0;
            st3_q  <= '0;
            st4_q  <= '0;
            en1_q  <= 1'b0;
            en2_q  <= 1'b0;
            hkw_q  <= '0;
            sig1_q <= '0;
            ch_q   <= '0;
            sig0_q <= '0;
            maj_q  <= '0;
            t1_q   <= '0;
            t2_q   <= '0;
        end else begin
            st1_q  <= state_i;
            en1_q  <= en_i;
            hkw_q  <= state_i.h + kw_i;
            sig1_q <= big_sigma1(state_i.e);
            ch_q   <= ch(state_i.e, state_i.f, state_i.g);
            sig0_q <= big_sigma0(state_i.a);
            maj_q  <= maj(state_i.a, state_i.b, state_i.c);
            st2_q  <= st1_q;
            en2_q  <= en1_q;
            t1_q   <= hkw_q + sig1_q + ch_q;
            t2_q   <= sig0_q + maj_q;
            st3_q  <= rnd_res;
            st4_q  <= st3_q;
        end
    end

    assign state_o = st4_q;

endmodule

// File: rtl/sha2_multi_ctx_core.sv
// rtl/sha2_multi_ctx_core.sv - time-interleaved multi-context SHA-256/224 compression engine.
module sha2_multi_ctx_core
    import sha2_pkg::*;
#(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = $clog2(NUM_CTX)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    output logic [CTX_W-1:0]   slot_o,
    input  logic               start_valid_i,
    output logic               start_ready_o,
    input  logic               start_first_i,
    input  logic               start_mode_i,
    input  logic               w_valid_i,
    input  logic [31:0]        w_i,
    output logic [5:0]         rnd_o,
    output logic               w_ready_o,
    output logic               digest_valid_o,
    output logic [CTX_W-1:0]   digest_ctx_o,
    output logic [255:0]       digest_o
);

    localparam int EXTRA = NUM_CTX - 4;

    logic [CTX_W-1:0] slot_q;
    ctx_state_e       ctx_q [NUM_CTX];
    logic [5:0]       rnd_q [NUM_CTX];
    sha2_mode_e       mode_q [NUM_CTX];
    sha2_work_t       h_q [NUM_CTX];

    ctx_state_e       cur_st;
    ctx_state_e       ctx_nxt;
    sha2_work_t       ring_out;
    sha2_work_t       pipe_in;
    sha2_work_t       pipe_out;
    sha2_work_t       iv_sel;
    sha2_work_t       start_state;
    sha2_work_t       new_h;
    logic             accept;
    logic             do_round;
    logic             fin;
    logic [31:0]      kw;

    logic             digest_valid_q;
    logic [CTX_W-1:0] digest_ctx_q;
    logic [255:0]     digest_q;

    assign kw = K_TAB[rnd_o] + w_i;

    sha2_round_pipe u_round_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (do_round),
        .state_i (pipe_in),
        .kw_i    (kw),
        .state_o (pipe_out)
    );

    // Pad the ring so a context's state comes back exactly on its next slot.
    generate
        if (EXTRA == 0) begin : g_no_dly
            assign ring_out = pipe_out;
        end else begin : g_dly
            sha2_work_t dly_q [EXTRA];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < EXTRA; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= pipe_out;
                    for (int i = 1; i < EXTRA; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign ring_out = dly_q[EXTRA-1];
        end
    endgenerate

    always_comb begin
        cur_st        = ctx_q[slot_q];
        ctx_nxt       = cur_st;
        rnd_o         = rnd_q[slot_q];
        start_ready_o = (cur_st == CTX_IDLE) && !flush_i;
        w_ready_o     = (cur_st == CTX_ACTIVE);
        accept        = start_valid_i && start_ready_o;
        iv_sel        = start_mode_i ? IV_SHA224 : IV_SHA256;
        start_state   = start_first_i ? iv_sel : h_q[slot_q];
        new_h         = add_work(h_q[slot_q], ring_out);
        pipe_in       = ring_out;
        do_round      = 1'b0;
        fin           = 1'b0;
        case (cur_st)
            CTX_IDLE: begin
                if (accept) begin
                    ctx_nxt = CTX_ACTIVE;
                    pipe_in = start_state;
                end
            end
            CTX_ACTIVE: begin
                if (w_valid_i) begin
                    do_round = 1'b1;
                    if (rnd_o == 6'd63) begin
                        ctx_nxt = CTX_FINAL;
                    end
                end
            end
            CTX_FINAL: begin
                fin     = 1'b1;
                ctx_nxt = CTX_IDLE;
            end
            default: ctx_nxt = CTX_IDLE;
        endcase
        if (flush_i) begin
            ctx_nxt = CTX_IDLE;
            fin     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q         <= '0;
            digest_valid_q <= 1'b0;
            digest_ctx_q   <= '0;
            digest_q       <= '0;
            for (int i = 0; i < NUM_CTX; i++) begin
                ctx_q[i]  <= CTX_IDLE;
                rnd_q[i]  <= '0;
                mode_q[i] <= MODE_SHA256;
                h_q[i]    <= IV_SHA256;
            end
        end else begin
            slot_q         <= (slot_q == CTX_W'(NUM_CTX - 1)) ? '0 : slot_q + CTX_W'(1);
            digest_valid_q <= fin;
            if (flush_i) begin
                for (int i = 0; i < NUM_CTX; i++) begin
                    ctx_q[i] <= CTX_IDLE;
                end
            end else begin
                ctx_q[slot_q] <= ctx_nxt;
                if (accept) begin
                    rnd_q[slot_q] <= '0;
                    if (start_first_i) begin
                        h_q[slot_q]    <= iv_sel;
                        mode_q[slot_q] <= sha2_mode_e'(start_mode_i);
                    end
                end
                if (do_round) begin
                    rnd_q[slot_q] <= rnd_q[slot_q] + 6'd1;
                end
                if (fin) begin
                    h_q[slot_q]  <= new_h;
                    digest_ctx_q <= slot_q;
                    digest_q     <= (mode_q[slot_q] == MODE_SHA224) ? {new_h[255:32], 32'h0} : new_h;
                end
            end
        end
    end

    assign slot_o         = slot_q;
    assign digest_valid_o = digest_valid_q;
    assign digest_ctx_o   = digest_ctx_q;
    assign digest_o       = digest_q;

endmodule

// File: tb/tb_sha2_multi_ctx_core.sv
// tb/tb_sha2_multi_ctx_core.sv - scoreboard bench for the multi-context SHA-2 engine.
module tb_sha2_multi_ctx_core;

    localparam int NCTX = 4;
    localparam int LAT  = 65 * NCTX;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071, 32'h80000000, 32'h0};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_224   = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic [1:0]   slot_o;
    logic         start_valid_i;
    logic         start_ready_o;
    logic         start_first_i;
    logic         start_mode_i;
    logic         w_valid_i;
    logic [31:0]  w_i;
    logic [5:0]   rnd_o;
    logic         w_ready_o;
    logic         digest_valid_o;
    logic [1:0]   digest_ctx_o;
    logic [255:0] digest_o;

    always #5 clk = ~clk;

    sha2_multi_ctx_core #(.NUM_CTX(NCTX)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .slot_o         (slot_o),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .start_first_i  (start_first_i),
        .start_mode_i   (start_mode_i),
        .w_valid_i      (w_valid_i),
        .w_i            (w_i),
        .rnd_o          (rnd_o),
        .w_ready_o      (w_ready_o),
        .digest_valid_o (digest_valid_o),
        .digest_ctx_o   (digest_ctx_o),
        .digest_o       (digest_o)
    );

    typedef struct {
        int           ctx;
        logic [255:0] dig;
        bit           chk;
        int           due;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [31:0]  wsch [NCTX][64];
    int           bphase [NCTX];
    int           rcnt [NCTX];
    bit           pend [NCTX];
    bit           pmode [NCTX];
    bit           pfirst [NCTX];
    bit           pchk [NCTX];
    logic [255:0] pexp [NCTX];
    bit           stall_en = 1'b0;
    bit           flush_req = 1'b0;
    int           rst_cnt = 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic int find_ctx(input int c);
        foreach (exp_q[i]) begin
            if (exp_q[i].ctx == c) return i;
        end
        return -1;
    endfunction

    task automatic clear_bench();
        exp_q.delete();
        for (int i = 0; i < NCTX; i++) begin
            bphase[i] = 0;
            rcnt[i]   = 0;
            pend[i]   = 1'b0;
        end
    endtask

    task automatic launch(input int c, input logic [511:0] blk, input bit mode, input bit first,
                          input logic [255:0] e, input bit chk);
        for (int t = 0; t < 16; t++) wsch[c][t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            wsch[c][t] = ssig1(wsch[c][t-2]) + wsch[c][t-7] + ssig0(wsch[c][t-15]) + wsch[c][t-16];
        pmode[c]  = mode;
        pfirst[c] = first;
        pexp[c]   = e;
        pchk[c]   = chk;
        pend[c]   = 1'b1;
    endtask

    function automatic bit ctx_done(input int c);
        return !pend[c] && bphase[c] == 0;
    endfunction

    task automatic wait_ctx(input int c);
        bit ok = 1'b0;
        for (int k = 0; k < 4000 && !ok; k++) begin
            @(negedge clk);
            #2;
            ok = ctx_done(c);
        end
        if (!ok) check("timeout_ctx", 0, 1);
    endtask

    task automatic wait_all();
        for (int c = 0; c < NCTX; c++) wait_ctx(c);
    endtask

    task automatic wait_rnd(input int c, input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            #2;
            ok = (rcnt[c] >= n);
        end
        if (!ok) check("timeout_rnd", 0, 1);
    endtask

    task automatic run_four();
        launch(0, BLK_ABC, 1'b0, 1'b1, DIG_ABC, 1'b1);
        launch(1, BLK_EMPTY, 1'b0, 1'b1, DIG_EMPTY, 1'b1);
        launch(2, BLK_ABC, 1'b1, 1'b1, DIG_224, 1'b1);
        launch(3, BLK_TWO1, 1'b0, 1'b1, '0, 1'b0);
        wait_ctx(3);
        launch(3, BLK_TWO2, 1'b0, 1'b0, DIG_TWO, 1'b1);
        wait_all();
    endtask

    // Driver and scoreboard monitor: one pass per cycle, half a period before the active edge.
    initial begin
        int c;
        int idx;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        start_valid_i = 1'b0;
        start_first_i = 1'b0;
        start_mode_i  = 1'b0;
        w_valid_i     = 1'b0;
        w_i           = '0;
        clear_bench();
        forever begin
            @(negedge clk);
            flush_i   = flush_req;
            flush_req = 1'b0;
            if (rst_cnt > 0) begin
                rst_ni = 1'b0;
                rst_cnt--;
                clear_bench();
            end else begin
                rst_ni = 1'b1;
            end
            #1;
            c             = int'(slot_o);
            start_valid_i = 1'b0;
            start_first_i = 1'($urandom);
            start_mode_i  = 1'($urandom);
            w_valid_i     = 1'b0;
            w_i           = $urandom;
            if (digest_valid_o) begin
                idx = find_ctx(int'(digest_ctx_o));
                if (idx < 0) begin
                    check("unexpected_digest", 1, 0);
                end else begin
                    if (exp_q[idx].chk) check("digest", digest_o, exp_q[idx].dig);
                    check("latency", 256'(cyc), 256'(exp_q[idx].due));
                    bphase[exp_q[idx].ctx] = 0;
                    exp_q.delete(idx);
                end
            end
            if (rst_ni) begin
                check("start_ready", start_ready_o, bphase[c] == 0 && !flush_i);
                check("w_ready", w_ready_o, bphase[c] == 1);
                if (flush_i) begin
                    start_valid_i = 1'b1;
                end else if (bphase[c] == 0 && pend[c] && start_ready_o) begin
                    start_valid_i = 1'b1;
                    start_first_i = pfirst[c];
                    start_mode_i  = pmode[c];
                    pend[c]       = 1'b0;
                    bphase[c]     = 1;
                    rcnt[c]       = 0;
                    exp_q.push_back('{ctx: c, dig: pexp[c], chk: pchk[c], due: cyc + 1 + LAT});
                end else if (bphase[c] != 0) begin
                    start_valid_i = 1'($urandom);
                end
                if (w_ready_o && rcnt[c] < 64) begin
                    check("rnd", rnd_o, 256'(rcnt[c]));
                    if (stall_en && c == 1 && $urandom_range(0, 99) < 30) begin
                        idx = find_ctx(c);
                        if (idx >= 0) exp_q[idx].due += NCTX;
                    end else begin
                        w_valid_i = 1'b1;
                        w_i       = wsch[c][rcnt[c]];
                        rcnt[c]++;
                        if (rcnt[c] == 64) bphase[c] = 2;
                    end
                end
                if (flush_i) clear_bench();
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #2;
        check("rst_slot", slot_o, 0);
        check("rst_rnd", rnd_o, 0);
        check("rst_start_ready", start_ready_o, 1);
        check("rst_w_ready", w_ready_o, 0);
        check("rst_dvalid", digest_valid_o, 0);
        check("rst_dctx", digest_ctx_o, 0);
        check("rst_digest", digest_o, 0);
        repeat (3) @(negedge clk);
        #2;

        launch(0, BLK_ABC, 1'b0, 1'b1, DIG_ABC, 1'b1);
        wait_all();
        launch(2, BLK_ABC, 1'b1, 1'b1, DIG_224, 1'b1);
        wait_all();
        launch(3, BLK_TWO1, 1'b0, 1'b1, '0, 1'b0);
        wait_ctx(3);
        launch(3, BLK_TWO2, 1'b1, 1'b0, DIG_TWO, 1'b1);
        wait_all();

        run_four();
        stall_en = 1'b1;
        run_four();
        stall_en = 1'b0;

        launch(0, BLK_ABC, 1'b0, 1'b1, DIG_ABC, 1'b1);
        wait_rnd(0, 30);
        flush_req = 1'b1;
        repeat (8) @(negedge clk);
        #2;

        launch(1, BLK_ABC, 1'b0, 1'b1, DIG_ABC, 1'b1);
        wait_rnd(1, 40);
        rst_cnt = 2;
        @(negedge clk);
        #2;
        check("mid_rst_slot", slot_o, 0);
        check("mid_rst_dvalid", digest_valid_o, 0);
        check("mid_rst_ready", start_ready_o, 1);
        repeat (8) @(negedge clk);
        #2;

        launch(0, BLK_ABC, 1'b0, 1'b1, DIG_ABC, 1'b1);
        wait_all();
        repeat (4) @(negedge clk);
        #2;
        check("queue_empty", 256'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
